// File: rtl/duration_meter.sv
// Measures the period and high time of an asynchronous input in clock cycles,
// publishing both on every rising edge once a full period has been observed.
module duration_meter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        d,
    output logic [31:0] q,
    output logic [31:0] duty_cycle
);
    localparam int unsigned      CNT_W   = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ds;
    logic                   ds_d;
    logic                   rise;
    logic                   timeout_hit;
    logic                   armed;
    logic                   armed_nxt;
    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       high_cnt;
    logic [CNT_W-1:0]       per_inc;
    logic [CNT_W-1:0]       high_inc;
    logic [CNT_W-1:0]       per_cnt_nxt;
    logic [CNT_W-1:0]       high_cnt_nxt;
    logic [CNT_W-1:0]       q_nxt;
    logic [CNT_W-1:0]       duty_nxt;

    // Input synchronizer plus one-cycle history for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            ds_d   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            ds_d   <= ds;
        end
    end

    assign ds   = sync_q[SYNC_STAGES-1];
    assign rise = ds & ~ds_d;

    // Saturating increments so a stalled input never wraps back into range
    assign per_inc  = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_W'(1);
    assign high_inc = (!ds || high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_W'(1);

    // Only an armed block can time out, so the clear fires once per stall
    assign timeout_hit = (TIMEOUT != 32'd0) && armed && (per_cnt == TIMEOUT);

    // Next-state: a rise wins over a coincident timeout
    always_comb begin
        per_cnt_nxt  = per_inc;
        high_cnt_nxt = high_inc;
        armed_nxt    = armed;
        q_nxt        = q;
        duty_nxt     = duty_cycle;
        if (rise) begin
            if (armed) begin
                q_nxt    = per_cnt;
                duty_nxt = high_cnt;
            end
            per_cnt_nxt  = CNT_W'(1);
            high_cnt_nxt = CNT_W'(1);
            armed_nxt    = 1'b1;
        end else if (timeout_hit) begin
            q_nxt     = '0;
            duty_nxt  = '0;
            armed_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per_cnt    <= '0;
            high_cnt   <= '0;
            armed      <= 1'b0;
            q          <= '0;
            duty_cycle <= '0;
        end else begin
            per_cnt    <= per_cnt_nxt;
            high_cnt   <= high_cnt_nxt;
            armed      <= armed_nxt;
            q          <= q_nxt;
            duty_cycle <= duty_nxt;
        end
    end

endmodule

// File: tb/tb_duration_meter.sv
// Scoreboard bench for duration_meter: each generated rising edge queues the
// expected period/high-time pair and the cycle at which it must appear.
`timescale 1ps/100fs
module tb_duration_meter;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT     = 50;
    localparam int unsigned LAT         = SYNC_STAGES + 1;

    typedef struct {
        int unsigned due;
        logic [31:0] q;
        logic [31:0] duty;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        d     = 1'b0;
    logic [31:0] q;
    logic [31:0] duty_cycle;

    exp_t        sb[$];
    int unsigned cyc       = 0;
    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;
    logic [31:0] exp_q     = '0;
    logic [31:0] exp_duty  = '0;
    bit          tb_armed  = 1'b0;
    int unsigned prev_h    = 0;
    int unsigned prev_l    = 0;

    duration_meter #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (32'(TIMEOUT))
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .d         (d),
        .q         (q),
        .duty_cycle(duty_cycle)
    );

    always #1 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    endtask

    // Retire due scoreboard entries, then check the held outputs every cycle
    always @(negedge clock) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_q    = sb[0].q;
            exp_duty = sb[0].duty;
            void'(sb.pop_front());
        end
        check("q", q, exp_q);
        check("duty_cycle", duty_cycle, exp_duty);
        check("duty_le_q", 32'(duty_cycle <= q), 32'd1);
    end

    // One period: rise, h cycles high, l cycles low; entered and left at a negedge
    task automatic pulse(input int unsigned h, input int unsigned l);
        if (tb_armed)
            sb.push_back('{due: cyc + LAT, q: 32'(prev_h + prev_l), duty: 32'(prev_h)});
        if (h + l > TIMEOUT)
            sb.push_back('{due: cyc + LAT + TIMEOUT, q: 32'd0, duty: 32'd0});
        tb_armed = (h + l <= TIMEOUT);
        prev_h   = h;
        prev_l   = l;
        d = 1'b1;
        repeat (h) @(negedge clock);
        d = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic pat_a(input int unsigned n);
        repeat (n) pulse(5, 10);
    endtask

    task automatic pat_b(input int unsigned n);
        repeat (n) pulse(10, 10);
    endtask

    initial begin
        // Reset held while d toggles: outputs must stay 0
        repeat (3) begin
            @(negedge clock); d = 1'b1;
            repeat (2) @(negedge clock);
            d = 1'b0;
            repeat (2) @(negedge clock);
        end
        check("reset_q", q, 32'd0);
        check("reset_duty", duty_cycle, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        pat_a(12);
        pat_b(6);
        repeat (3) begin
            pat_a(10);
            pat_b(10);
        end

        // Rise coincident with timeout count: rise wins, q = TIMEOUT
        pat_a(2);
        pulse(5, 45);
        pat_a(3);

        // Stuck low: timeout clears, next edge re-arms, then measurement resumes
        pulse(5, 60);
        pat_a(4);

        // Stuck high
        pulse(70, 5);
        pat_a(4);

        // Asynchronous reset mid-period during pattern B
        pat_b(4);
        d = 1'b1;
        repeat (4) @(negedge clock);
        #0.3 reset = 1'b0;
        #0.2;
        check("async_rst_q", q, 32'd0);
        check("async_rst_duty", duty_cycle, 32'd0);
        sb.delete();
        exp_q    = '0;
        exp_duty = '0;
        tb_armed = 1'b0;
        d        = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        pat_b(4);
        pulse(5, 5);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
        check("drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
